stream_demux1to4: RTL

STREAM_DEMUX1TO4 -- requirements
Module: stream_demux1to4

---
 rtl/stream_demux1to4.sv | 76 +++++++
 1 files changed

// File: rtl/stream_demux1to4.sv
// One-to-four stream demultiplexer: each destination owns a 2-entry FIFO,
// so one stalled sink never blocks traffic routed to the others.
module stream_demux1to4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [31:0]        out_count
);

    // Handshake: a word moves on a rising edge only when valid && ready are
    // both high; valid never waits on ready, and in_ready never looks at out_ready.

    // Occupancy of every channel, two bits per channel, channel i at [2*i +: 2].
    logic [7:0] occ_flat;

    // A full target stays not-ready even if it drains this cycle, which keeps
    // in_ready a function of registered occupancy and in_sel only.
    always_comb begin
        in_ready = (occ_flat[{in_sel, 1'b0} +: 2] != 2'd2);
    end

    genvar ch;
    generate
        for (ch = 0; ch < 4; ch++) begin : g_ch
            logic [WIDTH-1:0] mem [2];
            logic             wr_ptr;
            logic             rd_ptr;
            logic [1:0]       occ;
            logic [7:0]       cnt;
            logic             push;
            logic             pop;

            assign push = in_valid && in_ready && (in_sel == 2'(ch));
            assign pop  = out_valid[ch] && out_ready[ch];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= 1'b0;
                    rd_ptr <= 1'b0;
                    occ    <= 2'd0;
                    cnt    <= 8'd0;
                end else begin
                    if (push) wr_ptr <= ~wr_ptr;
                    if (pop) begin
                        rd_ptr <= ~rd_ptr;
                        cnt    <= cnt + 8'd1;
                    end
                    case ({push, pop})
                        2'b10:   occ <= occ + 2'd1;
                        2'b01:   occ <= occ - 2'd1;
                        default: occ <= occ;
                    endcase
                end
            end

            // Payload storage needs no reset: it is only visible while occupancy is nonzero.
            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr] <= in_data;
            end

            assign occ_flat[2*ch +: 2]          = occ;
            assign out_valid[ch]                = (occ != 2'd0);
            assign out_data[ch*WIDTH +: WIDTH]  = (occ != 2'd0) ? mem[rd_ptr] : '0;
            assign out_count[ch*8 +: 8]         = cnt;
        end
    endgenerate

endmodule
